lpgbt_uplink_link_ctrl: RTL and testbench

LPGBT_UPLINK_LINK_CTRL -- requirements
Module: lpgbt_uplink_link_ctrl

---
 rtl/lpgbt_uplink_link_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_lpgbt_uplink_link_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpgbt_uplink_link_ctrl.sv
// lpGBT uplink link controller.
// Brings the uplink up by pulsing the datapath reset, waiting for the uplink
// ready indication, and requiring it to stay asserted before declaring the
// link up. Failed attempts are retried, optionally with the MGT rx polarity
// flipped. After MAX_RETRIES attempts the controller parks in FAILED.
// Losing lock while the link is up restarts bring-up and is counted.
module lpgbt_uplink_link_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 8
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        enable_i,
  input  logic        auto_pol_i,
  input  logic        pol_init_i,
  input  logic        force_reset_i,
  input  logic        uplinkrdy_i,
  output logic        uplinkRst_o,
  output logic        mgt_rxpolarity_o,
  output logic        link_up_o,
  output logic        fail_o,
  output logic [2:0]  state_o,
  output logic [3:0]  retry_cnt_o,
  output logic [15:0] lock_loss_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_LINK_UP   = 3'd4,
    ST_FAILED    = 3'd5
  } state_t;

  // One timer is shared by RESET, WAIT_LOCK and STABLE; it is sized for the
  // largest of the three limits so it can never wrap.
  localparam int TMAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int TMAX   = (TMAX_A > STABLE_CYCLES) ? TMAX_A : STABLE_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);

  // Terminal counts: the timer starts at 0 on state entry, so the last
  // cycle of a phase of N cycles sees the value N-1.
  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LAST  = 4'(MAX_RETRIES - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pol_q, pol_d;
  logic [3:0]    retry_q, retry_d;
  logic [15:0]   lock_loss_q, lock_loss_d;
  logic          rdy_meta_q, rdy_meta_d;
  logic          rdy_s_q, rdy_s_d;
  logic          uplink_rst_q, uplink_rst_d;
  logic          link_up_q, link_up_d;
  logic          fail_q, fail_d;
  logic          retry_req;

  // Two-flop synchronizer for the clk40-domain ready; only rdy_s_q is used.
  always_comb begin
    rdy_meta_d = uplinkrdy_i;
    rdy_s_d    = rdy_meta_q;
  end

  // Next-state logic: enable_i low wins, then force_reset_i, then the FSM.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pol_d       = pol_q;
    retry_d     = retry_q;
    lock_loss_d = lock_loss_q;
    retry_req   = 1'b0;

    if (!enable_i) begin
      // Counters and polarity are kept so software can inspect them.
      state_d = ST_IDLE;
      timer_d = '0;
    end else if (force_reset_i || (state_q == ST_IDLE)) begin
      // Fresh bring-up: start from the configured polarity, no retries.
      state_d = ST_RESET;
      timer_d = '0;
      pol_d   = pol_init_i;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (timer_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock takes precedence over a timeout in the same cycle.
          if (rdy_s_q) begin
            state_d = ST_STABLE;
            timer_d = '0;
          end else if (timer_q == LOCK_LAST) begin
            retry_req = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!rdy_s_q) begin
            retry_req = 1'b1;
          end else if (timer_q == STABLE_LAST) begin
            state_d = ST_LINK_UP;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_LINK_UP: begin
          // A lost lock restarts bring-up with the polarity that worked.
          if (!rdy_s_q) begin
            if (lock_loss_q != 16'hFFFF) begin
              lock_loss_d = lock_loss_q + 16'd1;
            end
            retry_d = '0;
            state_d = ST_RESET;
            timer_d = '0;
          end
        end
        ST_FAILED: begin
          state_d = ST_FAILED;
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase

      // Retry action shared by lock timeout and loss of lock in STABLE.
      if (retry_req) begin
        timer_d = '0;
        if (retry_q == RETRY_LAST) begin
          state_d = ST_FAILED;
        end else begin
          retry_d = retry_q + 4'd1;
          if (auto_pol_i) begin
            pol_d = ~pol_q;
          end
          state_d = ST_RESET;
        end
      end
    end
  end

  // Status outputs are registered from the next state so they change
  // together with state_o and never glitch.
  always_comb begin
    uplink_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESET);
    link_up_d    = (state_d == ST_LINK_UP);
    fail_d       = (state_d == ST_FAILED);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      pol_q        <= 1'b0;
      retry_q      <= '0;
      lock_loss_q  <= '0;
      rdy_meta_q   <= 1'b0;
      rdy_s_q      <= 1'b0;
      uplink_rst_q <= 1'b1;
      link_up_q    <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pol_q        <= pol_d;
      retry_q      <= retry_d;
      lock_loss_q  <= lock_loss_d;
      rdy_meta_q   <= rdy_meta_d;
      rdy_s_q      <= rdy_s_d;
      uplink_rst_q <= uplink_rst_d;
      link_up_q    <= link_up_d;
      fail_q       <= fail_d;
    end
  end

  assign uplinkRst_o      = uplink_rst_q;
  assign mgt_rxpolarity_o = pol_q;
  assign link_up_o        = link_up_q;
  assign fail_o           = fail_q;
  assign state_o          = state_q;
  assign retry_cnt_o      = retry_q;
  assign lock_loss_cnt_o  = lock_loss_q;

endmodule

// File: tb/tb_lpgbt_uplink_link_ctrl.sv
// Bench for lpgbt_uplink_link_ctrl with small parameters.
// Table of multi-cycle vectors, hand-written corner sequences, and a
// randomized run scored against a phase/countdown reference model.
module tb_lpgbt_uplink_link_ctrl;

  localparam int RSTC  = 4;
  localparam int LOCKT = 20;
  localparam int STABC = 8;
  localparam int MAXR  = 3;

  // Spec state encoding
  localparam int S_IDLE = 0, S_RESET = 1, S_WAIT = 2, S_STABLE = 3, S_UP = 4, S_FAIL = 5;

  logic        clk;
  logic        rst_n;
  logic        enable_i, auto_pol_i, pol_init_i, force_reset_i, uplinkrdy_i;
  logic        uplinkRst_o, mgt_rxpolarity_o, link_up_o, fail_o;
  logic [2:0]  state_o;
  logic [3:0]  retry_cnt_o;
  logic [15:0] lock_loss_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  lpgbt_uplink_link_ctrl #(
    .RST_CYCLES(RSTC), .LOCK_TIMEOUT(LOCKT), .STABLE_CYCLES(STABC), .MAX_RETRIES(MAXR)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .enable_i(enable_i),
    .auto_pol_i(auto_pol_i),
    .pol_init_i(pol_init_i),
    .force_reset_i(force_reset_i),
    .uplinkrdy_i(uplinkrdy_i),
    .uplinkRst_o(uplinkRst_o),
    .mgt_rxpolarity_o(mgt_rxpolarity_o),
    .link_up_o(link_up_o),
    .fail_o(fail_o),
    .state_o(state_o),
    .retry_cnt_o(retry_cnt_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phases with a countdown of cycles left; the synchronizer is a 2-deep
  // delay line holding the last two sampled ready values.
  int m_state, m_left, m_retry, m_llc;
  bit m_pol;
  bit m_sync[$];

  function automatic void model_reset();
    m_state = S_IDLE; m_left = 0; m_retry = 0; m_llc = 0; m_pol = 1'b0;
    m_sync = '{1'b0, 1'b0};
  endfunction

  function automatic void model_start_reset();
    m_state = S_RESET;
    m_left  = RSTC;
  endfunction

  function automatic void model_retry();
    if (m_retry == MAXR - 1) begin
      m_state = S_FAIL;
    end else begin
      m_retry = m_retry + 1;
      if (auto_pol_i) m_pol = !m_pol;
      model_start_reset();
    end
  endfunction

  // One rising edge: decide on the ready seen two edges ago.
  function automatic void model_step();
    bit rs;
    rs = m_sync[0];
    if (!enable_i) begin
      m_state = S_IDLE;
    end else if (force_reset_i || m_state == S_IDLE) begin
      m_pol = pol_init_i;
      m_retry = 0;
      model_start_reset();
    end else if (m_state == S_RESET) begin
      m_left = m_left - 1;
      if (m_left == 0) begin m_state = S_WAIT; m_left = LOCKT; end
    end else if (m_state == S_WAIT) begin
      if (rs) begin
        m_state = S_STABLE; m_left = STABC;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) model_retry();
      end
    end else if (m_state == S_STABLE) begin
      if (!rs) model_retry();
      else begin
        m_left = m_left - 1;
        if (m_left == 0) m_state = S_UP;
      end
    end else if (m_state == S_UP) begin
      if (!rs) begin
        if (m_llc < 65535) m_llc = m_llc + 1;
        m_retry = 0;
        model_start_reset();
      end
    end
    void'(m_sync.pop_front());
    m_sync.push_back(uplinkrdy_i);
  endfunction

  function automatic logic [26:0] model_vec();
    logic rst_e, up_e, fl_e;
    rst_e = (m_state == S_IDLE) || (m_state == S_RESET);
    up_e  = (m_state == S_UP);
    fl_e  = (m_state == S_FAIL);
    return {3'(m_state), rst_e, m_pol, up_e, fl_e, 4'(m_retry), 16'(m_llc)};
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; returns at the next falling edge.
  task automatic tick(input logic en, input logic frc, input logic apol,
                      input logic pinit, input logic rdy);
    enable_i = en; force_reset_i = frc; auto_pol_i = apol;
    pol_init_i = pinit; uplinkrdy_i = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    enable_i = 0; force_reset_i = 0; auto_pol_i = 0; pol_init_i = 0; uplinkrdy_i = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic en, frc, apol, pinit, rdy;
    int n;
    logic [2:0] st;
    logic rst, pol;
    logic [3:0] retry;
    logic lnk, fl;
    logic [15:0] llc;
  } vec_t;

  vec_t vecs[15];

  // ---------------- scoreboard ----------------
  logic [26:0] exp_q[$];
  logic [26:0] act_v, exp_v;

  int  fail_cyc, n_rec, prev_st, rdy_hold;
  logic [3:0] rec_pol[4];
  logic [3:0] rec_retry[4];
  logic r_en, r_frc, r_apol, r_rdy;

  initial begin
    rst_n = 1'b0;
    enable_i = 0; force_reset_i = 0; auto_pol_i = 0; pol_init_i = 0; uplinkrdy_i = 0;
    model_reset();

    //  en frc apol pinit rdy  n   st rst pol retry lnk fl llc
    vecs[0]  = '{0,0,1,1,1, 3, 3'd0,1,0,4'd0,0,0,16'd0};
    vecs[1]  = '{1,0,1,1,1, 1, 3'd1,1,1,4'd0,0,0,16'd0};
    vecs[2]  = '{1,0,1,1,1, 3, 3'd1,1,1,4'd0,0,0,16'd0};
    vecs[3]  = '{1,0,1,1,1, 1, 3'd2,0,1,4'd0,0,0,16'd0};
    vecs[4]  = '{1,0,1,1,1, 1, 3'd3,0,1,4'd0,0,0,16'd0};
    vecs[5]  = '{1,0,1,1,1, 7, 3'd3,0,1,4'd0,0,0,16'd0};
    vecs[6]  = '{1,0,1,1,1, 1, 3'd4,0,1,4'd0,1,0,16'd0};
    vecs[7]  = '{1,0,1,1,0, 1, 3'd4,0,1,4'd0,1,0,16'd0};
    vecs[8]  = '{1,0,1,1,1, 1, 3'd4,0,1,4'd0,1,0,16'd0};
    vecs[9]  = '{1,0,1,1,1, 1, 3'd1,1,1,4'd0,0,0,16'd1};
    vecs[10] = '{1,0,1,1,1, 3, 3'd1,1,1,4'd0,0,0,16'd1};
    vecs[11] = '{1,0,1,1,1, 1, 3'd2,0,1,4'd0,0,0,16'd1};
    vecs[12] = '{1,0,1,1,1, 9, 3'd4,0,1,4'd0,1,0,16'd1};
    vecs[13] = '{1,1,1,0,1, 1, 3'd1,1,0,4'd0,0,0,16'd1};
    vecs[14] = '{0,1,1,0,1, 1, 3'd0,1,0,4'd0,0,0,16'd1};

    repeat (2) @(negedge clk);
    // Reset values while reset is held
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_uplinkrst", 32'(uplinkRst_o), 32'd1);
    check("rst_pol", 32'(mgt_rxpolarity_o), 32'd0);
    check("rst_link_fail", 32'({link_up_o, fail_o}), 32'd0);
    check("rst_counters", 32'({retry_cnt_o, lock_loss_cnt_o}), 32'd0);
    rst_n = 1'b1;

    // ---- table: nominal bring-up, lock loss, force, priority ----
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < vecs[i].n; k++)
        tick(vecs[i].en, vecs[i].frc, vecs[i].apol, vecs[i].pinit, vecs[i].rdy);
      check($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].st));
      check($sformatf("vec%0d_uplinkrst", i), 32'(uplinkRst_o), 32'(vecs[i].rst));
      check($sformatf("vec%0d_pol", i), 32'(mgt_rxpolarity_o), 32'(vecs[i].pol));
      check($sformatf("vec%0d_retry", i), 32'(retry_cnt_o), 32'(vecs[i].retry));
      check($sformatf("vec%0d_link_up", i), 32'(link_up_o), 32'(vecs[i].lnk));
      check($sformatf("vec%0d_fail", i), 32'(fail_o), 32'(vecs[i].fl));
      check($sformatf("vec%0d_lock_loss", i), 32'(lock_loss_cnt_o), 32'(vecs[i].llc));
    end

    // ---- auto-polarity retries until FAILED ----
    apply_reset();
    fail_cyc = -1; n_rec = 0; prev_st = S_IDLE;
    for (int c = 1; c <= 200; c++) begin
      tick(1, 0, 1, 0, 0);
      if (state_o == 3'(S_RESET) && prev_st != S_RESET && n_rec < 4) begin
        rec_pol[n_rec] = 4'(mgt_rxpolarity_o);
        rec_retry[n_rec] = retry_cnt_o;
        n_rec++;
      end
      if (c == 24) check("timeout_last_wait", 32'(state_o), 32'(S_WAIT));
      prev_st = int'(state_o);
      if (fail_o) begin fail_cyc = c; break; end
    end
    check("fail_cycle", 32'(fail_cyc), 32'd73);
    check("attempts", 32'(n_rec), 32'd3);
    if (n_rec == 3) begin
      check("pol_seq", 32'({rec_pol[0], rec_pol[1], rec_pol[2]}), 32'h010);
      check("retry_seq", 32'({rec_retry[0], rec_retry[1], rec_retry[2]}), 32'h012);
    end
    check("failed_state", 32'(state_o), 32'(S_FAIL));
    repeat (10) tick(1, 0, 1, 0, 1);
    check("failed_sticky", 32'({state_o, fail_o, uplinkRst_o}), 32'({3'd5, 1'b1, 1'b0}));
    tick(1, 1, 1, 1, 1);
    check("failed_force", 32'({state_o, retry_cnt_o, mgt_rxpolarity_o}), 32'({3'd1, 4'd0, 1'b1}));

    // ---- lock arriving on the timeout cycle wins ----
    apply_reset();
    for (int c = 1; c <= 22; c++) tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 1);
    check("lockwin_pre", 32'(state_o), 32'(S_WAIT));
    tick(1, 0, 0, 0, 1);
    check("lockwin_state", 32'(state_o), 32'(S_STABLE));
    check("lockwin_retry", 32'(retry_cnt_o), 32'd0);

    // ---- glitch at cycle 3 of STABLE ----
    apply_reset();
    for (int c = 1; c <= 6; c++) tick(1, 0, 1, 0, 1);
    check("glitch_in_stable", 32'(state_o), 32'(S_STABLE));
    tick(1, 0, 1, 0, 1);
    tick(1, 0, 1, 0, 1);
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 1, 0, 1);
    check("glitch_latency", 32'(state_o), 32'(S_STABLE));
    tick(1, 0, 1, 0, 1);
    check("glitch_state", 32'(state_o), 32'(S_RESET));
    check("glitch_retry", 32'(retry_cnt_o), 32'd1);
    check("glitch_pol", 32'(mgt_rxpolarity_o), 32'd1);

    // ---- async reset in WAIT_LOCK acts without a clock edge ----
    apply_reset();
    for (int c = 1; c <= 5; c++) tick(1, 0, 0, 0, 0);
    check("arst_pre_wait", 32'(state_o), 32'(S_WAIT));
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state_o), 32'd0);
    check("arst_uplinkrst", 32'(uplinkRst_o), 32'd1);
    @(negedge clk);
    check("arst_held", 32'({state_o, uplinkRst_o, retry_cnt_o}), 32'({3'd0, 1'b1, 4'd0}));
    rst_n = 1'b1;
    model_reset();

    // ---- randomized run against the reference model ----
    apply_reset();
    r_en = 1; r_frc = 0; r_apol = 1; r_rdy = 0; rdy_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (rdy_hold == 0) begin
        r_rdy = ($urandom_range(0, 2) != 0);
        rdy_hold = r_rdy ? $urandom_range(1, 60) : $urandom_range(1, 30);
      end
      rdy_hold--;
      r_en  = ($urandom_range(0, 149) != 0);
      r_frc = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) == 0) r_apol = !r_apol;
      tick(r_en, r_frc, r_apol, 1'($urandom_range(0, 1)), r_rdy);
      exp_q.push_back(model_vec());
      act_v = {state_o, uplinkRst_o, mgt_rxpolarity_o, link_up_o, fail_o,
               retry_cnt_o, lock_loss_cnt_o};
      exp_v = exp_q.pop_front();
      check($sformatf("rand_c%0d", c), 32'(act_v), 32'(exp_v));
      if (c % 900 == 899) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
